sum_seq_ctrl: RTL and testbench
===============================

# sum_seq_ctrl

Sequencer for the multi-cycle adder datapath: accepts full-width N-bit operands over a valid/ready handshake and pushes them through a W = N/CC-bit chunk adder over CC consecutive cycles, least-significant chunk first. It keeps the inter-chunk carry, assembles the N-bit result and presents it on an output valid/ready handshake. It sits between the operand source and result consumer wherever a wide sum must be time-multiplexed onto a narrow adder.

## Interface
Parameters:
- N, 1024, total operand/result width in bits.
- CC, 4, clock cycles per addition (chunk count). N must be divisible by CC; CC >= 1.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A.
- b  input  N  operand B.
- out_valid  output  1  result c/cout valid.
- out_ready  input  1  consumer accepts result.
- c  output  N  sum a+b mod 2^N.
- cout  output  1  carry out of bit N-1.

## Operation
- FSM states IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a, b into operand registers; clear carry; idx=0; go to RUN.
- RUN: each cycle, chunk k=idx, bits [k*W +: W]: {carry, c_reg[k]} = a_reg[k] + b_reg[k] + carry. Sum is W+1 bits wide; upper bit is the next carry. idx increments. After chunk CC-1, cout=final carry and go to DONE.
- DONE: out_valid=1. c and cout held stable. On out_ready go to IDLE.
- in_ready=1 only in IDLE. in_valid in RUN/DONE is ignored and not queued.
- a/b changes after acceptance have no effect.
- Carry is cleared at every acceptance. No carry passes between operations.
- CC=1: RUN is a single cycle doing the full N-bit add.
- Reset (any state, including mid-RUN or DONE): go to IDLE. The operation is aborted with no out_valid. Partial result is discarded.
- Reset values: in_ready=1, out_valid=0, c=0, cout=0. idx, carry and operand registers are 0.

## Timing
- Handshake cycle T (in_valid&&in_ready at edge T): RUN occupies edges T+1..T+CC. out_valid goes high after edge T+CC.
- Latency: CC cycles from accept to out_valid.
- c is the previous value or partial during RUN. Only valid when out_valid=1.
- DONE with out_ready=1 at edge D: IDLE after D, so in_ready=1 in cycle D+1.
- Minimum initiation interval: CC+2 cycles (accept, CC RUN, DONE handshake).
- out_valid stays high and c/cout stay stable until out_ready. No timeout.
- Outputs are all registered or decoded from state. There is no combinational path from in_valid/out_ready to any output.

## Structure
- Package sum_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - localparam W=N/CC;
  - idx width $clog2(CC) (min 1).
- Sub-module sum_chunk: combinational W-bit adder with cin/cout. It is instantiated once and driven by mux-selected operand chunks.
- Top level holds the FSM, idx counter, carry register and result register. Result chunk is written by idx.

## Test plan
- N=16, CC=4: a=0x00FF, b=0x0001 → c=0x0100, cout=0. out_valid rises exactly 4 cycles after the accept edge. in_ready low in between.
- N=16, CC=4: a=0xFFFF, b=0x0001 → c=0x0000, cout=1 (carry ripples through all 4 chunks).
- Backpressure: after the 0x1234+0x4321 result, hold out_ready=0 for 5 cycles and pulse in_valid with other operands → c=0x5555 held, out_valid=1 throughout, in_ready=0, new operands not accepted.
- Reset mid-RUN: assert rst after 2 chunks of 0xFFFF+0x0001 → immediately out_valid=0, c=0, cout=0, in_ready=1. Next op 0x1234+0x4321 → c=0x5555, cout=0 (no stale carry).
- Back-to-back ops: 0x8000+0x8000 (c=0, cout=1) then 0x0001+0x0001 with out_ready=1 → second result c=0x0002, cout=0. Second accept occurs exactly CC+2 cycles after the first.
- N=16, CC=1: 0x8000+0x8000 → c=0x0000, cout=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared types and width helpers for the time-multiplexed wide adder sequencer.
// Imported by the sequencer top and its chunk adder.
package sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_DEFAULT  = 1024;
  localparam int CC_DEFAULT = 4;

  // Chunk width W = N/CC; N must be a multiple of CC.
  function automatic int chunk_width(input int n, input int cc);
    return n / cc;
  endfunction

  // The chunk index counter keeps at least one bit even when CC == 1.
  function automatic int idx_width(input int cc);
    return (cc > 1) ? $clog2(cc) : 1;
  endfunction

endpackage

// File: rtl/sum_chunk.sv
// Combinational W-bit adder slice with carry in and carry out.
// One instance is shared by every chunk of a wide addition.
module sum_chunk #(
  parameter int W = 256
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = total[W-1:0];
  assign cout  = total[W];

endmodule

// File: rtl/sum_seq_ctrl.sv
// Sequencer that feeds N-bit operands through one W-bit chunk adder over CC cycles,
// LSB chunk first, and returns the assembled sum on a valid/ready handshake.
module sum_seq_ctrl
  import sum_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CC = CC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         cout
);

  localparam int W  = chunk_width(N, CC);
  localparam int IW = idx_width(CC);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    c_q, c_d;
  logic            cout_q, cout_d;

  logic [W-1:0]    a_chunk;
  logic [W-1:0]    b_chunk;
  logic [W-1:0]    chunk_sum;
  logic            chunk_cout;
  logic            last_chunk;

  // Select the operand slices addressed by the chunk counter.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < CC; k++) begin
      if (idx_q == IW'(k)) begin
        a_chunk = a_q[k*W +: W];
        b_chunk = b_q[k*W +: W];
      end
    end
  end

  assign last_chunk = (idx_q == IW'(CC - 1));

  sum_chunk #(
    .W(W)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < CC; k++) begin
          if (idx_q == IW'(k)) begin
            c_d[k*W +: W] = chunk_sum;
          end
        end
        carry_d = chunk_cout;
        if (last_chunk) begin
          cout_d  = chunk_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        // Result is held until the consumer takes it; nothing new is accepted.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Scoreboard bench for sum_seq_ctrl: one N=16/CC=4 instance and one N=16/CC=1 instance.
// Stimulus pushes expected results; negedge monitors pop and compare at each output handshake.
module tb_sum_seq_ctrl;

  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] c;
    logic         cout;
  } res_t;

  logic         clk;
  logic         rst;

  logic         in_valid4, in_ready4, out_valid4, out_ready4, cout4;
  logic [N-1:0] a4, b4, c4;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, cout1;
  logic [N-1:0] a1, b1, c1;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  res_t sb4[$];
  res_t sb1[$];
  res_t e4, e1;

  sum_seq_ctrl #(.N(N), .CC(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .c         (c4),
    .cout      (cout4)
  );

  sum_seq_ctrl #(.N(N), .CC(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .c         (c1),
    .cout      (cout1)
  );

  // Free-running clock and an edge counter used for latency and interval checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Issue one operand pair, queue its hand-computed result and return just after the accept edge.
  task automatic applyStimulus(input int sel, input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic [N-1:0] ec, input logic eco);
    res_t r;
    int   guard;
    r.c   = ec;
    r.cout = eco;
    guard = 0;
    if (sel == 4) begin
      a4 = av; b4 = bv; in_valid4 = 1'b1;
      sb4.push_back(r);
      while (!in_ready4 && guard < 40) begin tick(); guard++; end
      checkOutput("dut4 in_ready before accept", 32'(in_ready4), 32'd1);
      tick();
      in_valid4 = 1'b0;
    end else begin
      a1 = av; b1 = bv; in_valid1 = 1'b1;
      sb1.push_back(r);
      while (!in_ready1 && guard < 40) begin tick(); guard++; end
      checkOutput("dut1 in_ready before accept", 32'(in_ready1), 32'd1);
      tick();
      in_valid1 = 1'b0;
    end
  endtask

  task automatic waitDone(input int sel);
    int guard;
    guard = 0;
    if (sel == 4) begin
      while (!in_ready4 && guard < 40) begin tick(); guard++; end
      checkOutput("dut4 back to idle", 32'(in_ready4), 32'd1);
    end else begin
      while (!in_ready1 && guard < 40) begin tick(); guard++; end
      checkOutput("dut1 back to idle", 32'(in_ready1), 32'd1);
    end
  endtask

  // Monitor for the CC=4 instance: compare against the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (sb4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut4 unexpected result: got c=0x%0h cout=%0b, required none", c4, cout4);
      end else begin
        e4 = sb4.pop_front();
        checkOutput("dut4 c", 32'(c4), 32'(e4.c));
        checkOutput("dut4 cout", 32'(cout4), 32'(e4.cout));
      end
    end
  end

  // Monitor for the CC=1 instance.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (sb1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut1 unexpected result: got c=0x%0h cout=%0b, required none", c1, cout1);
      end else begin
        e1 = sb1.pop_front();
        checkOutput("dut1 c", 32'(c1), 32'(e1.c));
        checkOutput("dut1 cout", 32'(cout1), 32'(e1.cout));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, t1, guard;
    rst = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;

    // Reset values on both instances.
    #12;
    checkOutput("dut4 reset in_ready", 32'(in_ready4), 32'd1);
    checkOutput("dut4 reset out_valid", 32'(out_valid4), 32'd0);
    checkOutput("dut4 reset c", 32'(c4), 32'd0);
    checkOutput("dut4 reset cout", 32'(cout4), 32'd0);
    checkOutput("dut1 reset in_ready", 32'(in_ready1), 32'd1);
    checkOutput("dut1 reset out_valid", 32'(out_valid1), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] latency: 0x00FF + 0x0001");
    applyStimulus(4, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
    checkOutput("in_ready low after accept", 32'(in_ready4), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkOutput("out_valid low during run", 32'(out_valid4), 32'd0);
      checkOutput("in_ready low during run", 32'(in_ready4), 32'd0);
    end
    tick();
    checkOutput("out_valid 4 cycles after accept", 32'(out_valid4), 32'd1);
    waitDone(4);

    $display("[TB] full carry ripple: 0xFFFF + 0x0001");
    applyStimulus(4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    waitDone(4);

    $display("[TB] backpressure: 0x1234 + 0x4321");
    out_ready4 = 1'b0;
    applyStimulus(4, 16'h1234, 16'h4321, 16'h5555, 1'b0);
    guard = 0;
    while (!out_valid4 && guard < 40) begin tick(); guard++; end
    checkOutput("out_valid rises under backpressure", 32'(out_valid4), 32'd1);
    a4 = 16'h1111; b4 = 16'h2222; in_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("held out_valid", 32'(out_valid4), 32'd1);
      checkOutput("held c", 32'(c4), 32'h5555);
      checkOutput("held cout", 32'(cout4), 32'd0);
      checkOutput("in_ready low while holding", 32'(in_ready4), 32'd0);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    waitDone(4);
    tick();
    checkOutput("ignored operands not queued", 32'(out_valid4), 32'd0);

    $display("[TB] reset mid-run");
    applyStimulus(4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort out_valid", 32'(out_valid4), 32'd0);
    checkOutput("abort c", 32'(c4), 32'd0);
    checkOutput("abort cout", 32'(cout4), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready4), 32'd1);
    sb4.delete();
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(4, 16'h1234, 16'h4321, 16'h5555, 1'b0);
    waitDone(4);

    $display("[TB] back-to-back operations");
    a4 = 16'h8000; b4 = 16'h8000; in_valid4 = 1'b1;
    e4.c = 16'h0000; e4.cout = 1'b1;
    sb4.push_back(e4);
    checkOutput("first b2b in_ready", 32'(in_ready4), 32'd1);
    tick();
    t0 = cyc;
    a4 = 16'h0001; b4 = 16'h0001;
    e4.c = 16'h0002; e4.cout = 1'b0;
    sb4.push_back(e4);
    guard = 0;
    while (!in_ready4 && guard < 40) begin tick(); guard++; end
    tick();
    t1 = cyc;
    in_valid4 = 1'b0;
    checkOutput("initiation interval", 32'(t1 - t0), 32'd6);
    waitDone(4);

    $display("[TB] single-chunk instance");
    applyStimulus(1, 16'h8000, 16'h8000, 16'h0000, 1'b1);
    checkOutput("cc1 out_valid after accept", 32'(out_valid1), 32'd0);
    tick();
    checkOutput("cc1 out_valid 1 cycle later", 32'(out_valid1), 32'd1);
    waitDone(1);
    applyStimulus(1, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
    waitDone(1);

    tick();
    checkOutput("dut4 scoreboard drained", 32'(sb4.size()), 32'd0);
    checkOutput("dut1 scoreboard drained", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
